// File: rtl/rcl_stim_driver.sv
//------------------------------------------------------------------------------
// rcl_stim_driver : serialises one line/circle job to an RCL engine, awaits the
//                   reply and returns it with golden value, match and latency.
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rcl_stim_driver #(
    parameter int TIMEOUT = 16,
    parameter int GAP     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       job_valid,
    output logic       job_ready,
    input  logic [4:0] job_a,
    input  logic [4:0] job_b,
    input  logic [4:0] job_c,
    input  logic [4:0] job_m,
    input  logic [4:0] job_n,
    input  logic [4:0] job_k,
    output logic       in_valid,
    output logic [4:0] coef_L,
    output logic [4:0] coef_Q,
    input  logic       out_valid,
    input  logic [1:0] out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [1:0] res_out,
    output logic [1:0] res_expect,
    output logic       res_match,
    output logic       res_timeout,
    output logic [7:0] res_latency,
    output logic       spurious
);

    localparam logic [7:0] c_TIMEOUT  = 8'(TIMEOUT);
    localparam logic [3:0] c_GAP_LAST = 4'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEND0 = 3'd1,
        S_SEND1 = 3'd2,
        S_SEND2 = 3'd3,
        S_WAIT  = 3'd4,
        S_HOLD  = 3'd5,
        S_GAP   = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [4:0] r_a, r_b, r_c, r_m, r_n, r_k;
    logic [7:0] r_lat;
    logic [3:0] r_gap;
    logic       r_in_valid;
    logic [4:0] r_coef_l, r_coef_q;
    logic       r_res_valid;
    logic [1:0] r_res_out, r_res_expect;
    logic       r_res_match, r_res_timeout;
    logic [7:0] r_res_latency;
    logic       r_spurious;

    logic [7:0] w_lat_inc;
    logic       w_timeout_hit;

    assign w_lat_inc     = r_lat + 8'd1;
    assign w_timeout_hit = (w_lat_inc == c_TIMEOUT);

    // Golden model: everything widened to 22-bit signed so no product truncates.
    logic signed [21:0] w_a, w_b, w_c, w_m, w_n, w_k;
    logic signed [21:0] w_lhs, w_lin, w_rhs;
    logic        [1:0]  w_expect;

    assign w_a   = $signed({{17{r_a[4]}}, r_a});
    assign w_b   = $signed({{17{r_b[4]}}, r_b});
    assign w_c   = $signed({{17{r_c[4]}}, r_c});
    assign w_m   = $signed({{17{r_m[4]}}, r_m});
    assign w_n   = $signed({{17{r_n[4]}}, r_n});
    assign w_k   = $signed({17'd0, r_k});
    assign w_lhs = w_k * (w_a * w_a + w_b * w_b);
    assign w_lin = w_a * w_m + w_b * w_n + w_c;
    assign w_rhs = w_lin * w_lin;

    always_comb begin
        if (w_lhs > w_rhs) begin
            w_expect = 2'd2;
        end else if (w_lhs == w_rhs) begin
            w_expect = 2'd1;
        end else begin
            w_expect = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (job_valid) w_state_next = S_SEND0;
            S_SEND0: w_state_next = S_SEND1;
            S_SEND1: w_state_next = S_SEND2;
            S_SEND2: w_state_next = S_WAIT;
            S_WAIT:  if (out_valid || w_timeout_hit) w_state_next = S_HOLD;
            S_HOLD:  if (res_ready) w_state_next = (GAP > 0) ? S_GAP : S_IDLE;
            S_GAP:   if (r_gap == c_GAP_LAST) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_m           <= '0;
            r_n           <= '0;
            r_k           <= '0;
            r_lat         <= '0;
            r_gap         <= '0;
            r_in_valid    <= 1'b0;
            r_coef_l      <= '0;
            r_coef_q      <= '0;
            r_res_valid   <= 1'b0;
            r_res_out     <= '0;
            r_res_expect  <= '0;
            r_res_match   <= 1'b0;
            r_res_timeout <= 1'b0;
            r_res_latency <= '0;
            r_spurious    <= 1'b0;
        end else begin
            if (r_state == S_IDLE && job_valid) begin
                r_a <= job_a;
                r_b <= job_b;
                r_c <= job_c;
                r_m <= job_m;
                r_n <= job_n;
                r_k <= job_k;
            end

            // SEND0 is only entered from an accept, so it takes the live job inputs.
            r_in_valid <= 1'b0;
            r_coef_l   <= '0;
            r_coef_q   <= '0;
            case (w_state_next)
                S_SEND0: begin
                    r_in_valid <= 1'b1;
                    r_coef_l   <= job_a;
                    r_coef_q   <= job_m;
                end
                S_SEND1: begin
                    r_in_valid <= 1'b1;
                    r_coef_l   <= r_b;
                    r_coef_q   <= r_n;
                end
                S_SEND2: begin
                    r_in_valid <= 1'b1;
                    r_coef_l   <= r_c;
                    r_coef_q   <= r_k;
                end
                default: ;
            endcase

            if (r_state == S_SEND2) begin
                r_lat <= '0;
            end else if (r_state == S_WAIT) begin
                r_lat <= w_lat_inc;
            end

            if (r_state == S_WAIT && w_state_next == S_HOLD) begin
                r_res_out     <= out_valid ? out : 2'd0;
                r_res_timeout <= ~out_valid;
                r_res_latency <= w_lat_inc;
                r_res_expect  <= w_expect;
                r_res_match   <= out_valid && (out == w_expect);
            end
            r_res_valid <= (w_state_next == S_HOLD);

            if (r_state == S_HOLD) begin
                r_gap <= '0;
            end else if (r_state == S_GAP) begin
                r_gap <= r_gap + 4'd1;
            end

            if (out_valid && r_state != S_WAIT) begin
                r_spurious <= 1'b1;
            end
        end
    end

    assign job_ready   = (r_state == S_IDLE);
    assign in_valid    = r_in_valid;
    assign coef_L      = r_coef_l;
    assign coef_Q      = r_coef_q;
    assign res_valid   = r_res_valid;
    assign res_out     = r_res_out;
    assign res_expect  = r_res_expect;
    assign res_match   = r_res_match;
    assign res_timeout = r_res_timeout;
    assign res_latency = r_res_latency;
    assign spurious    = r_spurious;

endmodule

`default_nettype wire

// File: tb/tb_rcl_stim_driver.sv
//------------------------------------------------------------------------------
// tb_rcl_stim_driver : scoreboard bench for rcl_stim_driver (TIMEOUT=16, GAP=2).
// Revision 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rcl_stim_driver;

    localparam int c_TIMEOUT = 16;
    localparam int c_GAP     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       job_valid;
    logic       job_ready;
    logic [4:0] job_a, job_b, job_c, job_m, job_n, job_k;
    logic       in_valid;
    logic [4:0] coef_L, coef_Q;
    logic       out_valid;
    logic [1:0] out;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_out, res_expect;
    logic       res_match, res_timeout;
    logic [7:0] res_latency;
    logic       spurious;

    always #5 clk = ~clk;

    rcl_stim_driver #(.TIMEOUT(c_TIMEOUT), .GAP(c_GAP)) u_dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_a(job_a), .job_b(job_b), .job_c(job_c),
        .job_m(job_m), .job_n(job_n), .job_k(job_k),
        .in_valid(in_valid), .coef_L(coef_L), .coef_Q(coef_Q),
        .out_valid(out_valid), .out(out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_out(res_out), .res_expect(res_expect), .res_match(res_match),
        .res_timeout(res_timeout), .res_latency(res_latency),
        .spurious(spurious)
    );

    typedef struct {
        int res_out;
        int expv;
        int match;
        int tmo;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int golden(input int a, b, c, m, n, k);
        int lhs, rhs, lin;
        lhs = k * (a * a + b * b);
        lin = a * m + b * n + c;
        rhs = lin * lin;
        return (lhs > rhs) ? 2 : ((lhs == rhs) ? 1 : 0);
    endfunction

    // dly: WAIT cycle of the engine reply (1 = first); 0 means engine stays silent.
    task automatic run_job(input string tag, input int a, b, c, m, n, k,
                           input int dly, input int rep, input int hold, input bit jv_in_hold);
        exp_t       e;
        int         ok;
        int         waited;
        logic [4:0] ta, tb, tc, tm, tn, tk;
        ta = 5'(a); tb = 5'(b); tc = 5'(c); tm = 5'(m); tn = 5'(n); tk = 5'(k);
        e.expv    = golden(a, b, c, m, n, k);
        e.tmo     = (dly == 0 || dly > c_TIMEOUT) ? 1 : 0;
        e.res_out = e.tmo ? 0 : rep;
        e.lat     = e.tmo ? c_TIMEOUT : dly;
        e.match   = (!e.tmo && rep == e.expv) ? 1 : 0;
        sb.push_back(e);

        job_a = ta; job_b = tb; job_c = tc; job_m = tm; job_n = tn; job_k = tk;
        job_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (job_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
        check_eq({tag, " accept"}, ok, 1);
        if (ok == 0) begin
            job_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        tick();
        job_valid = 1'b0;
        check_eq({tag, " s0 vld"}, in_valid, 1);
        check_eq({tag, " s0 L"}, coef_L, ta);
        check_eq({tag, " s0 Q"}, coef_Q, tm);
        tick();
        check_eq({tag, " s1 vld"}, in_valid, 1);
        check_eq({tag, " s1 L"}, coef_L, tb);
        check_eq({tag, " s1 Q"}, coef_Q, tn);
        tick();
        check_eq({tag, " s2 vld"}, in_valid, 1);
        check_eq({tag, " s2 L"}, coef_L, tc);
        check_eq({tag, " s2 Q"}, coef_Q, tk);
        tick();
        check_eq({tag, " w vld"}, in_valid, 0);
        check_eq({tag, " w L"}, coef_L, 0);

        if (!e.tmo) begin
            for (int w = 1; w < dly; w++) tick();
            out_valid = 1'b1;
            out       = 2'(rep);
            tick();
            out_valid = 1'b0;
            out       = 2'd0;
        end

        ok = 0;
        waited = 0;
        for (int i = 0; i < 40; i++) begin
            if (res_valid) begin
                ok = 1;
                break;
            end
            tick();
            waited++;
        end
        check_eq({tag, " res_valid"}, ok, 1);
        check_eq({tag, " res wait"}, waited, e.tmo ? c_TIMEOUT : 0);

        e = sb.pop_front();
        check_eq({tag, " out"}, res_out, e.res_out);
        check_eq({tag, " expect"}, res_expect, e.expv);
        check_eq({tag, " match"}, res_match, e.match);
        check_eq({tag, " timeout"}, res_timeout, e.tmo);
        check_eq({tag, " latency"}, res_latency, e.lat);

        if (jv_in_hold) job_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            check_eq({tag, " hold vld"}, res_valid, 1);
            check_eq({tag, " hold jrdy"}, job_ready, 0);
            check_eq({tag, " hold out"}, res_out, e.res_out);
            check_eq({tag, " hold lat"}, res_latency, e.lat);
            check_eq({tag, " hold match"}, res_match, e.match);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        job_valid = 1'b0;
        check_eq({tag, " post vld"}, res_valid, 0);
    endtask

    initial begin
        rst = 1'b1;
        job_valid = 1'b0;
        job_a = '0; job_b = '0; job_c = '0; job_m = '0; job_n = '0; job_k = '0;
        out_valid = 1'b0;
        out = 2'd0;
        res_ready = 1'b0;
        tick();
        tick();
        check_eq("rst job_ready", job_ready, 1);
        check_eq("rst in_valid", in_valid, 0);
        check_eq("rst coef_L", coef_L, 0);
        check_eq("rst res_valid", res_valid, 0);
        check_eq("rst latency", res_latency, 0);
        check_eq("rst spurious", spurious, 0);
        rst = 1'b0;
        tick();

        run_job("t1", 1, 0, 0, 0, 0, 4, 1, 2, 0, 1'b0);
        run_job("t2", 1, 0, -2, 0, 0, 4, 1, 1, 0, 1'b0);
        run_job("t3", 1, 0, -3, 0, 0, 4, 1, 2, 0, 1'b0);
        run_job("t4", -16, -16, -16, -16, -16, 31, 1, 0, 0, 1'b0);
        run_job("tmo", 3, -2, 5, 1, 7, 9, 0, 0, 0, 1'b0);
        run_job("edge", 1, 0, 0, 0, 0, 4, c_TIMEOUT, 2, 0, 1'b0);
        run_job("dly3", 2, 3, -1, -4, 5, 17, 3, 1, 0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            run_job("rnd", $urandom_range(31) - 16, $urandom_range(31) - 16,
                    $urandom_range(31) - 16, $urandom_range(31) - 16,
                    $urandom_range(31) - 16, $urandom_range(31),
                    $urandom_range(4, 1), $urandom_range(2), 0, 1'b0);
        end
        check_eq("no spurious", spurious, 0);

        run_job("hold", 1, 0, -2, 0, 0, 4, 1, 1, 5, 1'b1);
        check_eq("gap1 jrdy", job_ready, 0);
        out_valid = 1'b1;
        out = 2'd2;
        tick();
        out_valid = 1'b0;
        out = 2'd0;
        check_eq("gap2 jrdy", job_ready, 0);
        check_eq("gap spurious", spurious, 1);
        tick();
        check_eq("gap end jrdy", job_ready, 1);
        check_eq("gap res_valid", res_valid, 0);

        run_job("after gap", 1, 0, 0, 0, 0, 4, 2, 2, 0, 1'b0);
        check_eq("sticky spurious", spurious, 1);

        job_a = 5'd3; job_b = 5'd1; job_c = 5'd2; job_m = 5'd4; job_n = 5'd5; job_k = 5'd6;
        job_valid = 1'b1;
        for (int i = 0; i < 20 && !job_ready; i++) tick();
        tick();
        job_valid = 1'b0;
        tick();
        check_eq("mid s1 vld", in_valid, 1);
        rst = 1'b1;
        tick();
        check_eq("mid rst in_valid", in_valid, 0);
        check_eq("mid rst coef_L", coef_L, 0);
        check_eq("mid rst coef_Q", coef_Q, 0);
        check_eq("mid rst res_valid", res_valid, 0);
        check_eq("mid rst job_ready", job_ready, 1);
        check_eq("mid rst spurious", spurious, 0);
        rst = 1'b0;
        tick();
        run_job("clean", 1, 0, -3, 0, 0, 4, 1, 0, 0, 1'b0);

        check_eq("sb empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
